// File: rtl/muldiv_unit.sv
// Iterative MUL/DIV unit: one iteration per clock, done pulses WIDTH+1 cycles after the accept edge.
// No handshake: stall holds the core through the accept cycle and RUN; start is ignored while busy.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               op_mul, op_div, accept;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] mul_next, div_next, step_next;
    logic [WIDTH-1:0]   raw_res, final_res;

    always_comb begin
        op_mul = (ALUControl == 4'b1000);
        op_div = (ALUControl == 4'b1001);
        accept = (state_q == S_IDLE) && start && (op_mul || op_div);
        abs_a  = a[WIDTH-1] ? -a : a;
        abs_b  = b[WIDTH-1] ? -b : b;

        // MUL: acc = {partial product, remaining multiplier bits}, shifted right each step.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

        // DIV: acc = {remainder, dividend/quotient}, shifted left each step.
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        rem_sub  = rem_sh[WIDTH-1:0] - opnd_q;
        div_next = (rem_sh >= {1'b0, opnd_q}) ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                                              : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

        step_next = is_div_q ? div_next : mul_next;
        raw_res   = neg_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
        if (dz_q)
            final_res = '1;
        else if (ovf_q)
            final_res = MOST_NEG;
        else
            final_res = raw_res;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_RUN;
                    count_d  = '0;
                    is_div_d = op_div;
                    neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
                    dz_d     = op_div && (b == '0);
                    ovf_d    = op_div && (a == MOST_NEG) && (b == '1);
                    opnd_d   = op_div ? abs_b : abs_a;
                    acc_d    = {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
                end
            end
            S_RUN: begin
                acc_d   = step_next;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH-1)) begin
                    state_d  = S_DONE;
                    result_d = final_res;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign stall  = accept || (state_q == S_RUN);
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): latency, stall shape, signed results, special cases, reset.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ALUControl;
    logic [31:0] a, b;
    logic        stall, busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
        .a(a), .b(b), .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; ALUControl = 4'b0000; a = '0; b = '0;
        #1;
        checks++;
        if ({stall, busy, done} !== 3'b000 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: stall=%b busy=%b done=%b result=%h, want 0 0 0 00000000",
                     stall, busy, done, result);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({stall, busy, done} !== 3'b000 || result !== 32'h0) begin
            errors++;
            $display("FAIL after_reset: stall=%b busy=%b done=%b result=%h, want 0 0 0 00000000",
                     stall, busy, done, result);
        end
    endtask

    // Issue one op in cycle 0 and follow it to cycle 40.
    task automatic run_op(input logic [3:0] ctl, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ex, input string nm);
        int done_cyc, n_done, stall_bad;
        logic [31:0] got;
        done_cyc = -1; n_done = 0; stall_bad = 0; got = 'x;
        @(negedge clk);
        start = 1'b1; ALUControl = ctl; a = av; b = bv;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL %s cycle0_stall: got %b want 1", nm, stall);
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    got = result;
                end
            end
            if (stall !== (c <= 32)) stall_bad++;
            if (c == 1) begin
                start = 1'b0; a = $urandom; b = $urandom;
            end
        end
        checks++;
        if (done_cyc != 33 || n_done != 1) begin
            errors++;
            $display("FAIL %s done_timing: first cycle %0d count %0d, want cycle 33 count 1",
                     nm, done_cyc, n_done);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL %s stall_shape: %0d bad cycles, want 0", nm, stall_bad);
        end
        checks++;
        if (got !== ex) begin
            errors++;
            $display("FAIL %s result: got %h want %h", nm, got, ex);
        end
        checks++;
        if (result !== ex || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s held_result: result=%h busy=%b, want %h 0", nm, result, busy, ex);
        end
    endtask

    task automatic test_mul();
        run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
        run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "mul_hi_drop");
        run_op(OP_MUL, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30, "mul_m5_m6");
    endtask

    task automatic test_div();
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
        run_op(OP_DIV, 32'd100, 32'd7, 32'd14, "div_100_7");
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
    endtask

    task automatic test_div_special();
        run_op(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by_zero");
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
    endtask

    task automatic test_ignore();
        int bad;
        bad = 0;
        @(negedge clk);
        start = 1'b1; ALUControl = 4'b0000; a = 32'd5; b = 32'd3;
        #1;
        if ({stall, busy, done} !== 3'b000) bad++;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if ({stall, busy, done} !== 3'b000) bad++;
        end
        start = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ignore_bad_op: %0d cycles with stall/busy/done set, want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int n_done;
        logic busy_pre;
        n_done = 0; busy_pre = 1'b0;
        @(negedge clk);
        start = 1'b1; ALUControl = OP_MUL; a = 32'd7; b = 32'hFFFF_FFFD;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 10) busy_pre = busy;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy_pre !== 1'b1 || busy !== 1'b0 || stall !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: busy_before=%b busy=%b stall=%b result=%h, want 1 0 0 00000000",
                     busy_pre, busy, stall, result);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d done pulses want 0", n_done);
        end
        run_op(OP_DIV, 32'd9, 32'd3, 32'd3, "div_after_reset");
    endtask

    task automatic test_back_to_back();
        int d1, d2, n_done;
        logic s33, s34;
        logic [31:0] r1, r2;
        d1 = -1; d2 = -1; n_done = 0; s33 = 1'bx; s34 = 1'bx; r1 = 'x; r2 = 'x;
        @(negedge clk);
        start = 1'b1; ALUControl = OP_MUL; a = 32'd7; b = 32'hFFFF_FFFD;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (d1 < 0) begin
                    d1 = c; r1 = result;
                end else if (d2 < 0) begin
                    d2 = c; r2 = result;
                end
            end
            if (c == 33) s33 = stall;
            if (c == 34) begin
                s34 = stall;
                ALUControl = OP_DIV; a = 32'd100; b = 32'd7;
            end
            if (c == 35) start = 1'b0;
        end
        checks++;
        if (d1 != 33 || d2 != 67 || n_done != 2) begin
            errors++;
            $display("FAIL b2b_timing: done at %0d,%0d count %0d, want 33,67 count 2", d1, d2, n_done);
        end
        checks++;
        if (s33 !== 1'b0 || s34 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stall: cycle33=%b cycle34=%b, want 0 1", s33, s34);
        end
        checks++;
        if (r1 !== 32'hFFFF_FFEB || r2 !== 32'd14) begin
            errors++;
            $display("FAIL b2b_results: got %h,%h want ffffffeb,0000000e", r1, r2);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
